ks_seq_adder: RTL and testbench

KS_SEQ_ADDER -- requirements
Module: ks_seq_adder

---
 rtl/ks_pkg.sv | 12 +
 rtl/kogge_stone_4bit.sv | 43 ++++
 rtl/ks_seq_adder.sv | 134 +++++++++++++
 tb/tb_ks_seq_adder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared definitions for the sequential Kogge-Stone adder: slice width and FSM states.
package ks_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/kogge_stone_4bit.sv
// 4-bit Kogge-Stone parallel-prefix adder used as the single slice engine.
module kogge_stone_4bit
   import ks_pkg::*;
(
   input  logic [SLICE_W-1:0] a_i,
   input  logic [SLICE_W-1:0] b_i,
   input  logic               cin_i,
   output logic [SLICE_W-1:0] sum_o,
   output logic               cout_o
);

   logic [SLICE_W-1:0] g0, p0, g1, p1, g2, p2;
   logic [SLICE_W:0]   c;

   assign g0   = a_i & b_i;
   assign p0   = a_i ^ b_i;
   assign c[0] = cin_i;

   // Two prefix levels (span 1, then span 2) cover all four bits; cin is folded in at the end.
   for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_bit
      if (gi >= 1) begin : g_l1
         assign g1[gi] = g0[gi] | (p0[gi] & g0[gi-1]);
         assign p1[gi] = p0[gi] & p0[gi-1];
      end else begin : g_l1_pass
         assign g1[gi] = g0[gi];
         assign p1[gi] = p0[gi];
      end

      if (gi >= 2) begin : g_l2
         assign g2[gi] = g1[gi] | (p1[gi] & g1[gi-2]);
         assign p2[gi] = p1[gi] & p1[gi-2];
      end else begin : g_l2_pass
         assign g2[gi] = g1[gi];
         assign p2[gi] = p1[gi];
      end

      assign c[gi+1]   = g2[gi] | (p2[gi] & cin_i);
      assign sum_o[gi] = p0[gi] ^ c[gi];
   end

   assign cout_o = c[SLICE_W];

endmodule

// File: rtl/ks_seq_adder.sv
// Sequential WIDTH-bit adder: one 4-bit Kogge-Stone core reused over WIDTH/4 slices,
// LSB slice first, with valid/ready handshakes on both sides and a synchronous flush.
module ks_seq_adder
   import ks_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
      $error("ks_seq_adder: WIDTH must be a multiple of 4 and at least 4");
   end

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;

   logic [SLICE_W-1:0] core_a, core_b, core_sum;
   logic               core_cout;

   always_comb begin
      core_a = '0;
      core_b = '0;
      for (int i = 0; i < NSLICE; i++) begin
         if (idx_q == IDX_W'(i)) begin
            core_a = a_q[i*SLICE_W +: SLICE_W];
            core_b = b_q[i*SLICE_W +: SLICE_W];
         end
      end
   end

   kogge_stone_4bit u_core (
      .a_i    (core_a),
      .b_i    (core_b),
      .cin_i  (carry_q),
      .sum_o  (core_sum),
      .cout_o (core_cout)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;

      // Flush beats accept, slice stepping and the output handshake alike.
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_d     = a;
                  b_d     = b;
                  carry_d = cin;
                  idx_d   = '0;
                  state_d = RUN;
               end
            end
            RUN: begin
               for (int i = 0; i < NSLICE; i++) begin
                  if (idx_q == IDX_W'(i)) begin
                     sum_d[i*SLICE_W +: SLICE_W] = core_sum;
                  end
               end
               carry_d = core_cout;
               idx_d   = idx_q + IDX_W'(1);
               if (idx_q == LAST_IDX) begin
                  cout_d  = core_cout;
                  idx_d   = '0;
                  state_d = DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_ks_seq_adder.sv
// Directed and randomized bench for ks_seq_adder (WIDTH=16) against an a+b+cin reference.
module tb_ks_seq_adder;

   localparam int WIDTH  = 16;
   localparam int NSLICE = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ks_seq_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept an operand set, wait for the result with a bound, and check latency and value.
   task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                         input logic op_c, input bit release_now);
      logic [WIDTH:0] ref_v;
      int n;
      ref_v = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_c};
      chk("pre_accept_in_ready", {31'd0, in_ready}, 32'd1);
      a = op_a; b = op_b; cin = op_c; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("latency", n, NSLICE);
      chk("sum", {16'd0, sum}, {16'd0, ref_v[WIDTH-1:0]});
      chk("cout", {31'd0, cout}, {31'd0, ref_v[WIDTH]});
      $display("op a=%h b=%h cin=%0d -> sum=%h cout=%0d latency=%0d", op_a, op_b, op_c, sum, cout, n);
      if (release_now) begin
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
         chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
      end
   endtask

   initial begin
      logic [WIDTH-1:0] held_sum;
      logic             held_cout;
      logic [WIDTH:0]   exp_q[$];
      logic [WIDTH:0]   ref_v;
      logic [WIDTH:0]   got;
      int               ncyc, results, last_res;

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; flush = 1'b0; out_ready = 1'b0;

      // Reset state
      tick();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_sum", {16'd0, sum}, 32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
      #1 rst = 1'b0;
      $display("reset released");

      // Scenario 1 (accept on first edge after reset)
      run_op(16'h1234, 16'h4321, 1'b1, 1'b1);
      chk("s1_sum", {16'd0, sum}, 32'h5556);

      // IDLE keeps result while inputs wander
      a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
      tick();
      chk("idle_hold_sum", {16'd0, sum}, 32'h5556);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // Scenario 2: full ripple
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b1);
      run_op(16'hFFFF, 16'h0000, 1'b1, 1'b1);
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);

      // Scenario 3: backpressure in DONE
      run_op(16'h8001, 16'h7FFF, 1'b0, 1'b0);
      held_sum = sum; held_cout = cout;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_sum", {16'd0, sum}, {16'd0, held_sum});
         chk("bp_cout", {31'd0, cout}, {31'd0, held_cout});
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_busy", {31'd0, busy}, 32'd1);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_release_idle", {31'd0, in_ready}, 32'd1);
      chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
      $display("backpressure sum=%h cout=%0d released", held_sum, held_cout);

      // Scenario 4: async reset at idx=2
      a = 16'h0F0F; b = 16'hF0F0; cin = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_sum", {16'd0, sum}, 32'd0);
      chk("arst_cout", {31'd0, cout}, 32'd0);
      #1 rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("arst_no_valid", {31'd0, out_valid}, 32'd0);
      end
      $display("async reset mid-run handled");
      run_op(16'h0001, 16'h0001, 1'b0, 1'b1);
      chk("arst_after_sum", {16'd0, sum}, 32'h0002);

      // Scenario 5a: flush in RUN at idx=1
      a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      held_sum = sum; held_cout = cout;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_run_idle", {31'd0, in_ready}, 32'd1);
      chk("flush_run_busy", {31'd0, busy}, 32'd0);
      chk("flush_run_sum", {16'd0, sum}, {16'd0, held_sum});
      chk("flush_run_cout", {31'd0, cout}, {31'd0, held_cout});
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("flush_run_no_valid", {31'd0, out_valid}, 32'd0);
      end
      $display("flush in RUN sum=%h", sum);

      // Flush blocks accept in IDLE
      flush = 1'b1; in_valid = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_idle_no_accept", {31'd0, busy}, 32'd0);

      // Scenario 5b: flush together with out_ready in DONE
      run_op(16'h0ABC, 16'h0123, 1'b1, 1'b0);
      held_sum = sum;
      flush = 1'b1; out_ready = 1'b1;
      tick();
      flush = 1'b0; out_ready = 1'b0;
      chk("flush_done_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_done_idle", {31'd0, in_ready}, 32'd1);
      chk("flush_done_sum", {16'd0, sum}, {16'd0, held_sum});
      tick();
      chk("flush_done_stays", {31'd0, out_valid}, 32'd0);
      $display("flush in DONE sum=%h", sum);

      // Scenario 6: 1000 random back-to-back operations
      in_valid = 1'b1; out_ready = 1'b1;
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      ref_v = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      exp_q.push_back(ref_v);
      results = 0; last_res = -1; ncyc = 0;
      while (results < 1000 && ncyc < 1000 * (NSLICE + 2) + 100) begin
         tick();
         ncyc++;
         if (out_valid === 1'b1) begin
            got = {cout, sum};
            if (exp_q.size() > 0) ref_v = exp_q.pop_front();
            else ref_v = '0;
            chk("rand_result", {15'd0, got}, {15'd0, ref_v});
            if (last_res >= 0) chk("rand_spacing", ncyc - last_res, NSLICE + 2);
            last_res = ncyc;
            results++;
            if (results % 100 == 0)
               $display("random op %0d result=%h expected=%h", results, got, ref_v);
         end
         if (in_ready === 1'b1) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
            ref_v = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            exp_q.push_back(ref_v);
         end else begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
         end
      end
      chk("rand_count", results, 1000);
      in_valid = 1'b0; out_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
